// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, fetches over an imem req/ack handshake, presents Instr.
// Optional fetch watchdog enabled by `define IF_TIMEOUT_EN (adds TIMEOUT_CYCLES and a live fetch_err).
module if_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
`ifdef IF_TIMEOUT_EN
  parameter int          TIMEOUT_CYCLES = 16,
`endif
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             PC_sel,
  input  logic             PC_LdEn,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instr,
  output logic             Instr_valid,
  output logic [31:0]      PC,
  output logic [CNT_W-1:0] instr_count,
  output logic             fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic             r_req;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      w_offset;
  logic [31:0]      w_pc_next;
  logic             w_timeout;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_offset = 32'h0;
    if (PC_sel)
      w_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    w_pc_next = r_pc + 32'd4 + w_offset;
  end

`ifdef IF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tcnt;
  logic          r_err;

  // Counter sits at zero outside FETCH, so it is implicitly cleared on every FETCH entry.
  assign w_timeout = (r_state == S_FETCH) && !imem_ack &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != S_FETCH || w_timeout)
        r_tcnt <= '0;
      else if (!imem_ack)
        r_tcnt <= r_tcnt + TW'(1);
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign fetch_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack || w_timeout) begin
            r_instr <= imem_ack ? imem_rdata : 32'h0;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (PC_LdEn) begin
            r_pc    <= w_pc_next;
            r_count <= r_count + CNT_W'(1);
            r_instr <= 32'h0;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_instr <= 32'h0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign PC          = r_pc;
  assign Instr       = r_instr;
  assign Instr_valid = r_valid;
  assign instr_count = r_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: handshake latency, next-PC arithmetic, stalls, mid-fetch reset, watchdog.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        Reset;
  logic        PC_sel;
  logic        PC_LdEn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] PC;
  logic [31:0] instr_count;
  logic        fetch_err;

  int vectors = 0;
  int errors  = 0;

  if_stage dut (
    .clk        (clk),
    .Reset      (Reset),
    .PC_sel     (PC_sel),
    .PC_LdEn    (PC_LdEn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Instr      (Instr),
    .Instr_valid(Instr_valid),
    .PC         (PC),
    .instr_count(instr_count),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Called in FETCH: wait `gap` cycles without ack, then ack with `word`.
  task automatic do_fetch(input logic [31:0] word, input int gap, input logic [31:0] exp_pc);
    for (int i = 0; i < gap; i++) begin
      chk("fetch_req",   {31'b0, imem_req}, 32'd1);
      chk("fetch_addr",  imem_addr, exp_pc);
      chk("fetch_instr", Instr, 32'h0);
      chk("fetch_valid", {31'b0, Instr_valid}, 32'd0);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("exec_valid", {31'b0, Instr_valid}, 32'd1);
    chk("exec_instr", Instr, word);
    chk("exec_req",   {31'b0, imem_req}, 32'd0);
  endtask

  // Called in EXEC: retire the held instruction.
  task automatic advance(input logic sel, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
    PC_LdEn = 1'b1;
    PC_sel  = sel;
    step();
    PC_LdEn = 1'b0;
    PC_sel  = 1'b0;
    chk("adv_pc",    PC, exp_pc);
    chk("adv_addr",  imem_addr, exp_pc);
    chk("adv_count", instr_count, exp_cnt);
    chk("adv_req",   {31'b0, imem_req}, 32'd1);
    chk("adv_valid", {31'b0, Instr_valid}, 32'd0);
    chk("adv_instr", Instr, 32'h0);
  endtask

  initial begin
    Reset      = 1'b1;
    PC_sel     = 1'b0;
    PC_LdEn    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    step();
    step();
    chk("rst_pc",    PC, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", {31'b0, Instr_valid}, 32'd0);
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_err",   {31'b0, fetch_err}, 32'd0);

    // 1: IDLE -> FETCH, ack two cycles after req, sequential advance.
    Reset = 1'b0;
    step();
    do_fetch(32'h8000_0010, 1, 32'h0);
    advance(1'b0, 32'h4, 32'd1);

    // Branch from 4 with offset 2 -> 4+4+8 = 0x10; 1-cycle ack latency.
    do_fetch(32'h0000_0002, 0, 32'h4);
    advance(1'b1, 32'h10, 32'd2);

    // 2: 0x10 + 4 + (3<<2) = 0x20.
    do_fetch(32'hFC00_0003, 2, 32'h10);
    advance(1'b1, 32'h20, 32'd3);

    // 3: offset -1 -> PC+4-4.
    do_fetch(32'h0000_FFFF, 0, 32'h20);
    advance(1'b1, 32'h20, 32'd4);
    // 0x24 + (-10<<2) = 0xFFFF_FFFC.
    do_fetch(32'h0000_FFF6, 1, 32'h20);
    advance(1'b1, 32'hFFFF_FFFC, 32'd5);
    // Sequential wrap; negative offset in Instr ignored with PC_sel = 0.
    do_fetch(32'h0000_8000, 0, 32'hFFFF_FFFC);
    advance(1'b0, 32'h0, 32'd6);

    // 4: stall three cycles, toggling PC_sel and offering stray acks.
    do_fetch(32'h1234_0008, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      PC_sel     = i[0];
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("stall_instr", Instr, 32'h1234_0008);
      chk("stall_pc",    PC, 32'h0);
      chk("stall_count", instr_count, 32'd6);
      chk("stall_req",   {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, Instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    advance(1'b1, 32'h24, 32'd7);

    // 5: reset mid-FETCH takes effect without a clock edge.
    Reset = 1'b1;
    #1;
    chk("mrst_req",   {31'b0, imem_req}, 32'd0);
    chk("mrst_pc",    PC, 32'h0);
    chk("mrst_instr", Instr, 32'h0);
    chk("mrst_valid", {31'b0, Instr_valid}, 32'd0);
    chk("mrst_count", instr_count, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    step();
    Reset = 1'b0;
    step();
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'b0, Instr_valid}, 32'd0);
    chk("late_ack_instr", Instr, 32'h0);
    chk("refetch_req",    {31'b0, imem_req}, 32'd1);
    chk("refetch_addr",   imem_addr, 32'h0);
    do_fetch(32'h0000_0001, 0, 32'h0);
    advance(1'b0, 32'h4, 32'd1);

`ifdef IF_TIMEOUT_EN
    // 6: no ack for 16 FETCH cycles -> Nop with sticky fetch_err.
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_valid", {31'b0, Instr_valid}, 32'd0);
      chk("to_wait_err",   {31'b0, fetch_err}, 32'd0);
      step();
    end
    chk("to_pre_valid", {31'b0, Instr_valid}, 32'd0);
    step();
    chk("to_valid", {31'b0, Instr_valid}, 32'd1);
    chk("to_instr", Instr, 32'h0);
    chk("to_err",   {31'b0, fetch_err}, 32'd1);
    advance(1'b1, 32'h8, 32'd2);
    chk("to_err_sticky", {31'b0, fetch_err}, 32'd1);
    do_fetch(32'h0000_0010, 0, 32'h8);
    chk("to_err_sticky2", {31'b0, fetch_err}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("to_err_clear", {31'b0, fetch_err}, 32'd0);
    step();
    Reset = 1'b0;
`else
    // Without the watchdog, FETCH waits indefinitely and fetch_err stays 0.
    for (int i = 0; i < 20; i++) step();
    chk("nto_valid", {31'b0, Instr_valid}, 32'd0);
    chk("nto_req",   {31'b0, imem_req}, 32'd1);
    chk("nto_err",   {31'b0, fetch_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
